// File: rtl/hotel_checkout_ctrl_pkg.sv
// Shared constants, FSM state type and room rate lookup for the hotel checkout controller.
package hotel_pkg;

    localparam int NUM_ROOMS  = 7;
    localparam int MAX_NIGHTS = 7;

    localparam logic [15:0] RATE_ROOM_LARGE = 16'd700;
    localparam logic [15:0] RATE_ROOM_STD   = 16'd400;
    localparam logic [15:0] RATE_ROOM_SUITE = 16'd500;
    localparam logic [15:0] AC_COST         = 16'd200;
    localparam logic [15:0] WIFI_COST       = 16'd100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEARCH,
        S_CALC,
        S_PRESENT,
        S_RELEASE
    } state_t;

    // Room order: room1, room2, room3_1, room3_2, room4_1, room4_2, room5
    function automatic logic [15:0] room_rate(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1:             room_rate = RATE_ROOM_LARGE;
            3'd2, 3'd3, 3'd4, 3'd5: room_rate = RATE_ROOM_STD;
            default:                room_rate = RATE_ROOM_SUITE;
        endcase
    endfunction

endpackage

// File: rtl/hotel_checkout_ctrl_if.sv
// Checkout request / bill handshake / room-release bundle between terminal and controller.
interface hotel_checkout_if;

    logic        checkout;
    logic [3:0]  id;
    logic        ac_selection;
    logic        wifi_selection;
    logic [15:0] bill;
    logic        bill_valid;
    logic        bill_ready;
    logic [6:0]  room_release;
    logic        not_found;
    logic        busy;

    modport master (
        output checkout, id, ac_selection, wifi_selection, bill_ready,
        input  bill, bill_valid, room_release, not_found, busy
    );

    modport slave (
        input  checkout, id, ac_selection, wifi_selection, bill_ready,
        output bill, bill_valid, room_release, not_found, busy
    );

endinterface

// File: rtl/hotel_stay_counter.sv
// Per-room night counter: cleared while vacant, counts day ticks while occupied, saturates.
module hotel_stay_counter
    import hotel_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       occupied,
    input  logic       day_tick,
    output logic [2:0] nights
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nights <= 3'd0;
        end else if (!occupied) begin
            nights <= 3'd0;
        end else if (day_tick && (nights != 3'(MAX_NIGHTS))) begin
            nights <= nights + 3'd1;
        end
    end

endmodule

// File: rtl/hotel_checkout_ctrl.sv
// Hotel checkout controller: finds the guest's room, bills stay plus extras, releases the room.
// Optional HOTEL_CHECKOUT_TAX_EN adds 12.5% (subtotal>>3) tax to the bill.
//
// state     | meaning
// S_IDLE    | waiting for a checkout request
// S_SEARCH  | scanning one room per cycle for the latched id
// S_CALC    | computing the bill for the matched room
// S_PRESENT | bill_valid held until the terminal accepts
// S_RELEASE | one-cycle room release strobe
module hotel_checkout_ctrl
    import hotel_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [27:0] occ_id,
    input  logic        day_tick,
    hotel_checkout_if.slave cif
);

    state_t      state;
    logic [3:0]  id_q;
    logic        ac_q;
    logic        wifi_q;
    logic [2:0]  idx_q;
    logic [15:0] bill_q;
    logic        bill_valid_q;
    logic [6:0]  release_q;
    logic        not_found_q;

    logic [2:0]  nights [NUM_ROOMS];
    logic [3:0]  cur_occ;
    logic [2:0]  nights_sel;
    logic [15:0] per_night;
    logic [15:0] nights_eff;
    logic [15:0] subtotal;
    logic [15:0] bill_calc;

    for (genvar r = 0; r < NUM_ROOMS; r++) begin : g_room
        hotel_stay_counter u_stay_counter (
            .clk      (clk),
            .rst_n    (rst_n),
            .occupied (occ_id[4*r +: 4] != 4'd0),
            .day_tick (day_tick),
            .nights   (nights[r])
        );
    end

    assign cur_occ = occ_id[{idx_q, 2'b00} +: 4];

    // Worst case 1000*7 (+1/8) stays well inside 16 bits.
    always_comb begin
        nights_sel = nights[idx_q];
        per_night  = room_rate(idx_q) + (ac_q ? AC_COST : 16'd0) + (wifi_q ? WIFI_COST : 16'd0);
        nights_eff = (nights_sel == 3'd0) ? 16'd1 : {13'd0, nights_sel};
        subtotal   = per_night * nights_eff;
`ifdef HOTEL_CHECKOUT_TAX_EN
        bill_calc  = subtotal + (subtotal >> 3);
`else
        bill_calc  = subtotal;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            id_q         <= 4'd0;
            ac_q         <= 1'b0;
            wifi_q       <= 1'b0;
            idx_q        <= 3'd0;
            bill_q       <= 16'd0;
            bill_valid_q <= 1'b0;
            release_q    <= 7'd0;
            not_found_q  <= 1'b0;
        end else begin
            not_found_q <= 1'b0;
            release_q   <= 7'd0;
            case (state)
                S_IDLE: begin
                    if (cif.checkout) begin
                        if (cif.id != 4'd0) begin
                            id_q   <= cif.id;
                            ac_q   <= cif.ac_selection;
                            wifi_q <= cif.wifi_selection;
                            idx_q  <= 3'd0;
                            state  <= S_SEARCH;
                        end else begin
                            not_found_q <= 1'b1;
                        end
                    end
                end
                S_SEARCH: begin
                    if (cur_occ == id_q) begin
                        state <= S_CALC;
                    end else if (idx_q == 3'(NUM_ROOMS - 1)) begin
                        not_found_q <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                S_CALC: begin
                    bill_q       <= bill_calc;
                    bill_valid_q <= 1'b1;
                    state        <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (cif.bill_ready) begin
                        bill_valid_q <= 1'b0;
                        release_q    <= 7'd1 << idx_q;
                        state        <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign cif.bill         = bill_q;
    assign cif.bill_valid   = bill_valid_q;
    assign cif.room_release = release_q;
    assign cif.not_found    = not_found_q;
    assign cif.busy         = (state != S_IDLE);

endmodule
